// File: rtl/halflife_sequencer.sv
// Half-life sequencer: loads a count, then halves it once per period
// using bursts of single-cycle down strobes until it reaches zero.
module halflife_sequencer #(
  parameter int WIDTH    = 4,
  parameter int HLW      = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] init_val,
  input  logic [HLW-1:0]   half_life,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_down,
  output logic [WIDTH-1:0] cur_val,
  output logic [3:0]       halvings,
  output logic             busy,
  output logic             done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [HLW-1:0]   hl_q, hl_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [3:0]       halv_q, halv_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [HLW-1:0]   per_q, per_d;
  logic [WIDTH-1:0] dec;

  assign dec = cur_q - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    hl_d    = hl_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    halv_d  = halv_q;
    presc_d = presc_q;
    per_d   = per_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          init_d  = init_val;
          hl_d    = (half_life == '0) ? HLW'(1) : half_life;
          halv_d  = '0;
        end
      end
      S_LOAD: begin
        cur_d   = init_q;
        presc_d = '0;
        per_d   = '0;
        state_d = (init_q == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (presc_q == PMAX) begin
          presc_d = '0;
          per_d   = per_q + HLW'(1);
          if (per_q == hl_q - HLW'(1)) begin
            state_d = S_STEP;
            tgt_d   = cur_q >> 1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_STEP: begin
        if (cur_q != tgt_q) begin
          cur_d = dec;
          // last pulse of the burst closes out this half-life
          if (dec == tgt_q) begin
            halv_d  = (halv_q == 4'hF) ? halv_q : halv_q + 4'd1;
            presc_d = '0;
            per_d   = '0;
            state_d = (dec == '0) ? S_DONE : S_WAIT;
          end
        end else begin
          presc_d = '0;
          per_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      init_q  <= '0;
      hl_q    <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      halv_q  <= '0;
      presc_q <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      hl_q    <= hl_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      halv_q  <= halv_d;
      presc_q <= presc_d;
      per_q   <= per_d;
    end
  end

  assign cnt_load     = (state_q == S_LOAD);
  assign cnt_load_val = (state_q == S_LOAD) ? init_q : '0;
  assign cnt_down     = (state_q == S_STEP) && (cur_q != tgt_q);
  assign cur_val      = cur_q;
  assign halvings     = halv_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_halflife_sequencer.sv
// Scoreboard bench for halflife_sequencer with a one-cycle prescaler:
// stimulus queues expected strobes, a negedge monitor pops and compares.
module tb_halflife_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] init_val;
  logic [7:0] half_life;
  logic       cnt_load, cnt_down, busy, done;
  logic [3:0] cnt_load_val, cur_val, halvings;

  halflife_sequencer #(.WIDTH(4), .HLW(8), .TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .init_val(init_val), .half_life(half_life),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_down(cnt_down), .cur_val(cur_val), .halvings(halvings),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 load (val = load value), 1 down (val = cur_val during pulse),
  // 2 done (val = cur_val); halv < 0 means not checked
  typedef struct {
    int kind;
    int at;
    int val;
    int halv;
  } ev_t;

  ev_t q[$];
  int applied = 0;
  int miscomp = 0;

  task automatic chk(string nm, int act, int req);
    applied++;
    if (act != req) begin
      miscomp++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic exp_ev(int k, int c, int v, int h);
    ev_t e;
    e.kind = k; e.at = c; e.val = v; e.halv = h;
    q.push_back(e);
  endtask

  task automatic exp_burst(int c, int from, int n);
    for (int i = 0; i < n; i++) exp_ev(1, c + i, from - i, -1);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    int  k;
    if (!reset && (cnt_load || cnt_down || done)) begin
      k = cnt_load ? 0 : (cnt_down ? 1 : 2);
      chk("load_down_excl", int'(cnt_load & cnt_down), 0);
      if (q.size() == 0) begin
        applied++;
        miscomp++;
        $display("FAIL unexpected_strobe: kind %0d at cycle %0d, expected none",
                 k, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_kind", k, e.kind);
        chk("ev_cycle", cyc, e.at);
        chk("ev_val", (k == 0) ? int'(cnt_load_val) : int'(cur_val), e.val);
        if (e.halv >= 0) chk("ev_halvings", int'(halvings), e.halv);
      end
    end
  end

  task automatic arm(output int s);
    @(negedge clk);
    s = cyc + 1;
  endtask

  task automatic fire(int iv, int hl);
    init_val  = 4'(iv);
    half_life = 8'(hl);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", int'(busy), 0);
    chk("queue_drained", q.size(), 0);
  endtask

  int s;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    init_val = '0; half_life = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_cur", int'(cur_val), 0);
    chk("rst_halv", int'(halvings), 0);
    reset = 1'b0;
    @(negedge clk);

    // basic 12 -> 6 -> 3 -> 1 -> 0, with an ignored start mid-run
    arm(s);
    exp_ev(0, s, 12, 0);
    exp_burst(s + 4, 12, 6);
    exp_burst(s + 13, 6, 3);
    exp_burst(s + 19, 3, 2);
    exp_burst(s + 24, 1, 1);
    exp_ev(2, s + 25, 0, 4);
    fire(12, 3);
    repeat (5) @(negedge clk);
    init_val = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("basic_idle_cyc", cyc, s + 26);
    chk("basic_cur", int'(cur_val), 0);
    chk("basic_halv", int'(halvings), 4);

    // zero init
    arm(s);
    exp_ev(0, s, 0, 0);
    exp_ev(2, s + 1, 0, 0);
    fire(0, 5);
    wait_idle();
    chk("zero_idle_cyc", cyc, s + 2);

    // half_life 0 behaves as 1
    arm(s);
    exp_ev(0, s, 2, 0);
    exp_burst(s + 2, 2, 1);
    exp_burst(s + 4, 1, 1);
    exp_ev(2, s + 5, 0, 2);
    fire(2, 0);
    wait_idle();
    chk("hl0_halv", int'(halvings), 2);

    // abort during second down pulse
    arm(s);
    exp_ev(0, s, 15, 0);
    exp_burst(s + 3, 15, 2);
    fire(15, 2);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_cur", int'(cur_val), 13);
    chk("abort_halv", int'(halvings), 0);
    chk("abort_down", int'(cnt_down), 0);
    chk("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("abort_queue", q.size(), 0);

    // reload after abort
    arm(s);
    exp_ev(0, s, 3, 0);
    exp_burst(s + 2, 3, 2);
    exp_burst(s + 5, 1, 1);
    exp_ev(2, s + 6, 0, 2);
    fire(3, 1);
    wait_idle();
    chk("reload_cur", int'(cur_val), 0);

    // start and abort together in IDLE
    @(negedge clk);
    init_val = 4'd7; half_life = 8'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("contend_busy", int'(busy), 0);
    chk("contend_load", int'(cnt_load), 0);
    repeat (2) @(negedge clk);

    // reset during WAIT
    arm(s);
    exp_ev(0, s, 9, 0);
    fire(9, 4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_load", int'(cnt_load), 0);
    chk("mrst_loadval", int'(cnt_load_val), 0);
    chk("mrst_down", int'(cnt_down), 0);
    chk("mrst_cur", int'(cur_val), 0);
    chk("mrst_halv", int'(halvings), 0);
    chk("mrst_done", int'(done), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mrst_after_busy", int'(busy), 0);
    chk("final_queue", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
    $finish;
  end

endmodule
